// File: rtl/mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : mem_writer
// Description : Loads a stream of valid/last qualified words into an internal
//               2**ADDR_WIDTH x DATA_WIDTH memory, starting at address 0 on
//               each start. A separate registered read port allows readback.
//               The IDLE -> LOAD -> DONE control FSM reports busy, done,
//               the accepted word count and a sticky error flag.
//               Optional feature macro: MEM_WRITER_CHECKSUM_EN
//                 defined   -> checksum is the running modulo-2**DATA_WIDTH
//                              sum of accepted words
//                 undefined -> checksum is tied to 0
// Revision    : 1.0 - initial release
// ============================================================================
module mem_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  accept;
  logic                  start_ok;
  logic                  at_last_addr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The block can only take words while loading; start is honoured only
  // outside LOAD so a pulse mid-load never disturbs the address.
  assign wr_ready     = (state == LOAD);
  assign accept       = wr_valid && wr_ready;
  assign start_ok     = start && (state != LOAD);
  assign at_last_addr = (addr == {ADDR_WIDTH{1'b1}});
  assign busy         = (state == LOAD);
  assign done         = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a load ends on the last word or when memory fills.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (accept && (wr_last || at_last_addr)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write address, word counter and sticky error flag.
  // The address holds at the top entry once full so it never wraps back
  // over word 0; the FSM is in DONE by then and no further write occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      wr_count <= '0;
      err      <= 1'b0;
    end else if (start_ok) begin
      addr     <= '0;
      wr_count <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        wr_count <= wr_count + 1'b1;
        if (!at_last_addr) begin
          addr <= addr + 1'b1;
        end
      end
      if (wr_valid && !wr_ready) begin
        err <= 1'b1;
      end
    end
  end

  // Memory write port; contents are never cleared, and reset blocks writes.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem[addr] <= wr_data;
    end
  end

  // Registered read port: read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

`ifdef MEM_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;

  // Running checksum of accepted words, wrapping at the data width.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (start_ok) begin
      sum <= '0;
    end else if (accept) begin
      sum <= sum + wr_data;
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_writer
// Description : Directed self-checking bench for mem_writer. Instance a uses
//               the default geometry; instance b uses ADDR_WIDTH=3 to reach
//               the memory-full boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_writer;

`ifdef MEM_WRITER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // instance a (ADDR_WIDTH = 10)
  logic        rst, start, wr_valid, wr_last, wr_ready, busy, done, err;
  logic [7:0]  wr_data, rd_data, checksum;
  logic [9:0]  rd_addr;
  logic [10:0] wr_count;

  // instance b (ADDR_WIDTH = 3)
  logic        b_rst, b_start, b_wr_valid, b_wr_last, b_wr_ready, b_busy, b_done, b_err;
  logic [7:0]  b_wr_data, b_rd_data, b_checksum;
  logic [2:0]  b_rd_addr;
  logic [3:0]  b_wr_count;

  // 50 MHz clock.
  always #10 clk = ~clk;

  mem_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_last(wr_last), .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .wr_count(wr_count), .err(err), .checksum(checksum)
  );

  mem_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .wr_data(b_wr_data), .wr_valid(b_wr_valid),
    .wr_last(b_wr_last), .wr_ready(b_wr_ready), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .busy(b_busy), .done(b_done), .wr_count(b_wr_count), .err(b_err), .checksum(b_checksum)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; b_rst = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0h expected 0", done); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %0h expected 0", wr_ready); end
    checks++; if (wr_count !== 11'd0) begin errors++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h expected 0", err); end
    checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum: got %0h expected 0", checksum); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    checks++; if (b_busy !== 1'b0 || b_wr_count !== 4'd0) begin errors++; $display("FAIL reset_b: got busy=%0h count=%0d expected 0/0", b_busy, b_wr_count); end
    rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_load_four();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL load_enter: got busy=%0h ready=%0h expected 1/1", busy, wr_ready); end
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'h11 * (i + 1)); wr_valid = 1'b1; wr_last = (i == 3);
      tick();
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL load_done: got done=%0h busy=%0h expected 1/0", done, busy); end
    checks++; if (wr_count !== 11'd4) begin errors++; $display("FAIL load_count: got %0d expected 4", wr_count); end
    checks++; if (checksum !== (CS_EN ? 8'hAA : 8'h00)) begin errors++; $display("FAIL load_checksum: got %0h expected %0h", checksum, (CS_EN ? 8'hAA : 8'h00)); end
    rd_addr = 10'd2; tick();
    checks++; if (rd_data !== 8'h33) begin errors++; $display("FAIL load_read2: got %0h expected 33", rd_data); end
    rd_addr = 10'd0; tick();
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL load_read0: got %0h expected 11", rd_data); end
  endtask

  task automatic test_err_idle();
    rst = 1'b1; tick(); rst = 1'b0;
    wr_data = 8'h5A; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %0h expected 1", err); end
    checks++; if (wr_count !== 11'd0) begin errors++; $display("FAIL err_count: got %0d expected 0", wr_count); end
    rd_addr = 10'd0; tick();
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL err_nowrite: got %0h expected 11", rd_data); end
    // start together with a valid word: start wins, word dropped, err cleared
    start = 1'b1; wr_valid = 1'b1; wr_data = 8'h5A; tick(); start = 1'b0; wr_valid = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0h expected 0", err); end
    checks++; if (busy !== 1'b1 || wr_count !== 11'd0) begin errors++; $display("FAIL start_valid: got busy=%0h count=%0d expected 1/0", busy, wr_count); end
    tick();
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL start_valid_nowrite: got %0h expected 11", rd_data); end
  endtask

  task automatic test_rst_mid_load();
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'hA1 + i); wr_valid = 1'b1; tick();
    end
    wr_valid = 1'b0;
    checks++; if (wr_count !== 11'd3) begin errors++; $display("FAIL mid_count: got %0d expected 3", wr_count); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_state: got busy=%0h done=%0h ready=%0h expected 0/0/0", busy, done, wr_ready); end
    checks++; if (wr_count !== 11'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", wr_count); end
    for (int j = 0; j < 3; j++) begin
      rd_addr = 10'(j); tick();
      checks++; if (rd_data !== 8'(8'hA1 + j)) begin errors++; $display("FAIL mid_readback[%0d]: got %0h expected %0h", j, rd_data, 8'(8'hA1 + j)); end
    end
  endtask

  task automatic test_restart();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_data = 8'(8'hB0 + i); wr_valid = 1'b1; tick();
    end
    wr_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1 || wr_count !== 11'd2) begin errors++; $display("FAIL restart_ignored: got busy=%0h count=%0d expected 1/2", busy, wr_count); end
    wr_data = 8'hB2; wr_valid = 1'b1; wr_last = 1'b1; tick(); wr_valid = 1'b0; wr_last = 1'b0;
    checks++; if (done !== 1'b1 || wr_count !== 11'd3) begin errors++; $display("FAIL restart_done: got done=%0h count=%0d expected 1/3", done, wr_count); end
    rd_addr = 10'd2; tick();
    checks++; if (rd_data !== 8'hB2) begin errors++; $display("FAIL restart_addr2: got %0h expected b2", rd_data); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || wr_count !== 11'd0) begin errors++; $display("FAIL done_start: got busy=%0h done=%0h count=%0d expected 1/0/0", busy, done, wr_count); end
    wr_data = 8'hC0; wr_valid = 1'b1; wr_last = 1'b1; tick(); wr_valid = 1'b0; wr_last = 1'b0;
    checks++; if (done !== 1'b1 || wr_count !== 11'd1) begin errors++; $display("FAIL done_start_load: got done=%0h count=%0d expected 1/1", done, wr_count); end
    rd_addr = 10'd0; tick();
    checks++; if (rd_data !== 8'hC0) begin errors++; $display("FAIL done_start_addr0: got %0h expected c0", rd_data); end
    rd_addr = 10'd1; tick();
    checks++; if (rd_data !== 8'hB1) begin errors++; $display("FAIL done_start_addr1: got %0h expected b1", rd_data); end
  endtask

  task automatic test_same_addr();
    rd_addr = 10'd0;
    start = 1'b1; tick(); start = 1'b0;
    wr_data = 8'hD0; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
    checks++; if (rd_data !== 8'hC0) begin errors++; $display("FAIL collide_old: got %0h expected c0", rd_data); end
    tick();
    checks++; if (rd_data !== 8'hD0) begin errors++; $display("FAIL collide_new: got %0h expected d0", rd_data); end
    checks++; if (checksum !== (CS_EN ? 8'hD0 : 8'h00)) begin errors++; $display("FAIL collide_checksum: got %0h expected %0h", checksum, (CS_EN ? 8'hD0 : 8'h00)); end
  endtask

  task automatic test_full();
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_wr_data = 8'(8'h80 + i); b_wr_valid = 1'b1; b_wr_last = 1'b0; tick();
    end
    b_wr_valid = 1'b0;
    checks++; if (b_done !== 1'b1 || b_wr_ready !== 1'b0) begin errors++; $display("FAIL full_done: got done=%0h ready=%0h expected 1/0", b_done, b_wr_ready); end
    checks++; if (b_wr_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", b_wr_count); end
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL full_err_clean: got %0h expected 0", b_err); end
    b_wr_data = 8'hFF; b_wr_valid = 1'b1; tick(); b_wr_valid = 1'b0;
    checks++; if (b_err !== 1'b1 || b_wr_count !== 4'd8) begin errors++; $display("FAIL full_overflow: got err=%0h count=%0d expected 1/8", b_err, b_wr_count); end
    b_rd_addr = 3'd7; tick();
    checks++; if (b_rd_data !== 8'h87) begin errors++; $display("FAIL full_mem7: got %0h expected 87", b_rd_data); end
    b_rd_addr = 3'd0; tick();
    checks++; if (b_rd_data !== 8'h80) begin errors++; $display("FAIL full_mem0: got %0h expected 80", b_rd_data); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_data = 8'h00; wr_valid = 1'b0; wr_last = 1'b0; rd_addr = 10'd0;
    b_rst = 1'b1; b_start = 1'b0; b_wr_data = 8'h00; b_wr_valid = 1'b0; b_wr_last = 1'b0; b_rd_addr = 3'd0;
    test_reset();
    test_load_four();
    test_err_idle();
    test_rst_mid_load();
    test_restart();
    test_same_addr();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of each stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz; one clock, all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a new load at address 0.
REQ-006 SHALL have port wr_data  input  DATA_WIDTH  word to store.
REQ-007 SHALL have port wr_valid  input  1  wr_data is valid this cycle.
REQ-008 SHALL have port wr_last  input  1  qualified by wr_valid; this is the final word of the load.
REQ-009 SHALL have port wr_ready  output  1  the block accepts a word this cycle.
REQ-010 SHALL have port rd_addr  input  ADDR_WIDTH  read address.
REQ-011 SHALL have port rd_data  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have port busy  output  1  high in LOAD.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port wr_count  output  ADDR_WIDTH+1  words accepted since the last start.
REQ-015 SHALL have port err  output  1  sticky; a word was offered while not ready.
REQ-016 SHALL have port checksum  output  DATA_WIDTH  running sum of accepted words (see Configuration).

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD and DONE.
REQ-018 SHALL transition IDLE->LOAD and DONE->LOAD on start; on entry, the write address, wr_count, err and checksum clear to 0.
REQ-019 SHALL ignore start while in LOAD, with no restart and no address change.
REQ-020 SHALL drive wr_ready = 1 iff state==LOAD (combinational from state).
REQ-021 SHALL treat accept as wr_valid && wr_ready; on accept, mem[addr] <= wr_data, addr++ and wr_count++ in that same cycle.
REQ-022 SHALL go LOAD->DONE on an accept with wr_last=1, or on an accept at addr = 2**ADDR_WIDTH-1 (full); the final word is written in both cases, and addr does not wrap into a further write.
REQ-023 SHALL hold done=1 in DONE until the next start; in DONE, wr_count keeps the total, e.g. 2**ADDR_WIDTH when full.
REQ-024 SHALL set err on wr_valid=1 while wr_ready=0, drop that word and leave it unwritten; err clears only on start or rst.
REQ-025 SHALL register the read port as rd_data <= mem[rd_addr] every cycle, with 1-cycle latency, independent of state.
REQ-026 SHALL return the old contents on a read and write to the same address in the same cycle, with the new value on the following cycle.
REQ-027 SHALL, when start and wr_valid occur in the same cycle in IDLE or DONE, not accept the word; err is cleared by the start, not set.

Reset
REQ-028 SHALL, on rst=1 at posedge clk, set state=IDLE, addr=0, wr_count=0, err=0, checksum=0, busy=0, done=0 and wr_ready=0; rst takes priority over start and over accepts.
REQ-029 SHALL, on rst in mid-LOAD, abort the load; words already written remain in memory, and memory contents are never reset.
REQ-030 SHALL reset rd_data to 0.

Configuration
REQ-031 SHALL compile the checksum logic only when macro MEM_WRITER_CHECKSUM_EN is defined; checksum then adds each accepted wr_data modulo 2**DATA_WIDTH, and is cleared on start/rst.
REQ-032 SHALL, without MEM_WRITER_CHECKSUM_EN, keep the checksum port and tie it to constant 0; all other behaviour is unchanged.

Verification
REQ-033 SHALL verify: rst, then start, then 4 accepted words 0x11,0x22,0x33,0x44 (last on 0x44) -> done=1, wr_count=4, rd_addr=2 gives rd_data=0x33 one cycle later, and checksum=0xAA when the macro is defined (0x00 otherwise).
REQ-034 SHALL verify: with ADDR_WIDTH=3, start and 8 accepts with wr_last=0 -> DONE after the 8th word, wr_count=8, wr_ready=0, mem[7]=8th word, mem[0] not overwritten.
REQ-035 SHALL verify: wr_valid=1 in IDLE with data 0x5A -> err=1, no write, wr_count=0; a subsequent start -> err=0.
REQ-036 SHALL verify: rst asserted after 3 accepts in LOAD -> IDLE, busy=0, wr_count=0; readback of addresses 0-2 returns the 3 written words.
REQ-037 SHALL verify: start pulsed in LOAD after 2 accepts -> ignored, next accept writes address 2; start in DONE -> wr_count=0 and the next word is written to address 0.
